// File: rtl/db9_pad_reader.sv
// Sega DB9 3/6-button pad initiator: drives TH through an 8-step poll and decodes
// the multiplexed pad pins into registered, active-high button outputs.
module db9_pad_reader #(
    parameter int SETTLE      = 64,
    parameter int POLL_CYCLES = 32768
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CE,
    input  logic [5:0] PIN,
    output logic       TH,
    output logic       P_UP,
    output logic       P_DOWN,
    output logic       P_LEFT,
    output logic       P_RIGHT,
    output logic       P_A,
    output logic       P_B,
    output logic       P_C,
    output logic       P_START,
    output logic       P_MODE,
    output logic       P_X,
    output logic       P_Y,
    output logic       P_Z,
    output logic       PRESENT,
    output logic       SIX_BTN,
    output logic       VALID
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STEP   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int IW = $clog2(POLL_CYCLES);
    localparam int TW = $clog2(SETTLE);
    localparam logic [IW-1:0] IDLE_LAST = IW'(POLL_CYCLES - 8 * SETTLE - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SETTLE - 1);

    // Button vector order: UP DOWN LEFT RIGHT A B C START MODE X Y Z (bit 11 down to 0)
    logic [1:0]    state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    step_q, step_d;
    logic          th_q, th_d;
    logic [5:0]    sync1_q, sync2_q;
    logic [11:0]   sh_btn_q, sh_btn_d;
    logic          sh_pres_q, sh_pres_d;
    logic          sh_six_q, sh_six_d;
    logic [11:0]   btn_q, btn_d;
    logic          present_q, present_d;
    logic          six_q, six_d;
    logic          valid_q, valid_d;
    logic [5:0]    s;

    assign s = ~sync2_q;

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        tick_d     = tick_q;
        step_d     = step_q;
        sh_btn_d   = sh_btn_q;
        sh_pres_d  = sh_pres_q;
        sh_six_d   = sh_six_q;
        btn_d      = btn_q;
        present_d  = present_q;
        six_d      = six_q;
        valid_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CE) begin
                    if (idle_cnt_q == IDLE_LAST) begin
                        state_d    = ST_STEP;
                        step_d     = 3'd0;
                        tick_d     = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
            end
            ST_STEP: begin
                if (CE) begin
                    if (tick_q == TICK_LAST) begin
                        case (step_q)
                            3'd0: begin
                                sh_btn_d[11] = s[0];
                                sh_btn_d[10] = s[1];
                                sh_btn_d[9]  = s[2];
                                sh_btn_d[8]  = s[3];
                                sh_btn_d[6]  = s[4];
                                sh_btn_d[5]  = s[5];
                            end
                            3'd1: begin
                                sh_btn_d[7] = s[4];
                                sh_btn_d[4] = s[5];
                                sh_pres_d   = s[2] & s[3];
                            end
                            3'd5: sh_six_d = &s[3:0];
                            3'd6: begin
                                sh_btn_d[0] = s[0];
                                sh_btn_d[1] = s[1];
                                sh_btn_d[2] = s[2];
                                sh_btn_d[3] = s[3];
                            end
                            default: ;
                        endcase
                        tick_d = '0;
                        if (step_q == 3'd7) begin
                            state_d = ST_COMMIT;
                        end else begin
                            step_d = step_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                // A 3-button pad leaves pins 1-4 undefined on the extra step, so its MODE/X/Y/Z are dropped
                if (!sh_pres_q) begin
                    btn_d = '0;
                end else if (!sh_six_q) begin
                    btn_d = sh_btn_q & 12'hFF0;
                end else begin
                    btn_d = sh_btn_q;
                end
                present_d  = sh_pres_q;
                six_d      = sh_pres_q & sh_six_q;
                valid_d    = 1'b1;
                idle_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // TH is registered from the next step so it toggles on the edge that ends a step
        th_d = (state_d == ST_STEP) ? ~step_d[0] : 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            idle_cnt_q <= '0;
            tick_q     <= '0;
            step_q     <= 3'd0;
            th_q       <= 1'b1;
            sync1_q    <= 6'h3F;
            sync2_q    <= 6'h3F;
            sh_btn_q   <= '0;
            sh_pres_q  <= 1'b0;
            sh_six_q   <= 1'b0;
            btn_q      <= '0;
            present_q  <= 1'b0;
            six_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            tick_q     <= tick_d;
            step_q     <= step_d;
            th_q       <= th_d;
            sync1_q    <= PIN;
            sync2_q    <= sync1_q;
            sh_btn_q   <= sh_btn_d;
            sh_pres_q  <= sh_pres_d;
            sh_six_q   <= sh_six_d;
            btn_q      <= btn_d;
            present_q  <= present_d;
            six_q      <= six_d;
            valid_q    <= valid_d;
        end
    end

    assign TH      = th_q;
    assign P_UP    = btn_q[11];
    assign P_DOWN  = btn_q[10];
    assign P_LEFT  = btn_q[9];
    assign P_RIGHT = btn_q[8];
    assign P_A     = btn_q[7];
    assign P_B     = btn_q[6];
    assign P_C     = btn_q[5];
    assign P_START = btn_q[4];
    assign P_MODE  = btn_q[3];
    assign P_X     = btn_q[2];
    assign P_Y     = btn_q[1];
    assign P_Z     = btn_q[0];
    assign PRESENT = present_q;
    assign SIX_BTN = six_q;
    assign VALID   = valid_q;

endmodule

// File: tb/tb_db9_pad_reader.sv
// Directed bench for db9_pad_reader with a behavioural 3/6-button Sega pad model.
module tb_db9_pad_reader;

    localparam int SETTLE      = 4;
    localparam int POLL_CYCLES = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce = 1'b1;
    logic [5:0] pin;
    logic       th;
    logic       p_up, p_down, p_left, p_right, p_a, p_b, p_c, p_start;
    logic       p_mode, p_x, p_y, p_z;
    logic       present, six_btn, valid;

    int n_checks = 0;
    int n_errors = 0;

    // Pad model state: mode 0 = unplugged, 1 = 3-button, 2 = 6-button
    int          pad_mode;
    logic [11:0] pad_btn;
    logic        ce_mode = 1'b0;
    int          ce_ph = 0;
    int          falls = 0;
    int          rises = 0;
    int          base = 0;
    int          tmo = 0;
    logic        th_prev = 1'b1;
    int          pf;
    logic [5:0]  s_m;

    db9_pad_reader #(.SETTLE(SETTLE), .POLL_CYCLES(POLL_CYCLES)) dut (
        .CLK(clk), .RESET(rst), .CE(ce), .PIN(pin), .TH(th),
        .P_UP(p_up), .P_DOWN(p_down), .P_LEFT(p_left), .P_RIGHT(p_right),
        .P_A(p_a), .P_B(p_b), .P_C(p_c), .P_START(p_start),
        .P_MODE(p_mode), .P_X(p_x), .P_Y(p_y), .P_Z(p_z),
        .PRESENT(present), .SIX_BTN(six_btn), .VALID(valid)
    );

    wire [11:0] btn_o = {p_up, p_down, p_left, p_right, p_a, p_b, p_c, p_start,
                         p_mode, p_x, p_y, p_z};

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ce_mode) begin
            ce_ph <= (ce_ph == 2) ? 0 : ce_ph + 1;
            ce    <= (ce_ph == 2);
        end else begin
            ce <= 1'b1;
        end
    end

    always @(negedge th) falls <= falls + 1;
    always @(posedge th) rises <= rises + 1;

    // TH-count timeout: after 100 clocks without a TH edge the pad restarts its sequence
    always @(posedge clk) begin
        th_prev <= th;
        if (th !== th_prev) tmo <= 0;
        else if (tmo < 1000) tmo <= tmo + 1;
        if (tmo == 100) base <= falls;
    end

    always_comb begin
        s_m = 6'h00;
        pf  = falls - base;
        if (pad_mode != 0) begin
            if (th) begin
                if (pad_mode == 2 && pf == 3)
                    s_m = {pad_btn[5], pad_btn[6], pad_btn[3], pad_btn[2], pad_btn[1], pad_btn[0]};
                else
                    s_m = {pad_btn[5], pad_btn[6], pad_btn[8], pad_btn[9], pad_btn[10], pad_btn[11]};
            end else begin
                if (pad_mode == 2 && pf == 3)
                    s_m = {pad_btn[4], pad_btn[7], 4'b1111};
                else if (pad_mode == 2 && pf >= 4)
                    s_m = {pad_btn[4], pad_btn[7], 4'b0000};
                else
                    s_m = {pad_btn[4], pad_btn[7], 2'b11, pad_btn[10], pad_btn[11]};
            end
        end
    end

    assign pin = ~s_m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [11:0] eb, input logic ep, input logic es);
        check({tag, "_btn"}, {20'd0, btn_o}, {20'd0, eb});
        check({tag, "_present"}, {31'd0, present}, {31'd0, ep});
        check({tag, "_six"}, {31'd0, six_btn}, {31'd0, es});
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!valid && cyc < 2000);
        check("valid_seen", {31'd0, valid}, 32'd1);
    endtask

    task automatic wait_falls(input int n);
        int target;
        target = falls + n;
        for (int i = 0; i < 2000 && falls < target; i++) @(negedge clk);
        check("th_falls_seen", {31'd0, falls >= target}, 32'd1);
    endtask

    task automatic measure_first_fall(input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (ce) cnt++;
            #1;
            if (!th) break;
        end
        check(tag, cnt, (POLL_CYCLES - 8 * SETTLE) + SETTLE);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc, f0, r0;
        rst      = 1'b1;
        pad_mode = 2;
        pad_btn  = 12'h091;
        #1;
        check("reset_th", {31'd0, th}, 32'd1);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check_outs("reset", 12'h000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 6-button pad, A+Z+START
        wait_valid(cyc);
        check("first_valid_cycles", cyc, 32'd257);
        check_outs("six", 12'h091, 1'b1, 1'b1);
        f0 = falls; r0 = rises;
        wait_valid(cyc);
        check("poll_period", cyc, 32'd257);
        check("th_falls_per_poll", falls - f0, 32'd4);
        check("th_rises_per_poll", rises - r0, 32'd4);
        check_outs("six_again", 12'h091, 1'b1, 1'b1);
        @(negedge clk);
        check("valid_pulse_width", {31'd0, valid}, 32'd0);

        // 3-button pad, UP+C
        pad_mode = 1;
        pad_btn  = 12'h820;
        wait_valid(cyc);
        check_outs("three", 12'h820, 1'b1, 1'b0);

        // no pad
        pad_mode = 0;
        wait_valid(cyc);
        check_outs("nopad", 12'h000, 1'b0, 1'b0);

        // pin change during step 3
        pad_mode = 1;
        pad_btn  = 12'h820;
        wait_valid(cyc);
        check_outs("mid_pre", 12'h820, 1'b1, 1'b0);
        wait_falls(2);
        pad_btn = 12'h400;
        wait_valid(cyc);
        check_outs("mid_old", 12'h820, 1'b1, 1'b0);
        wait_valid(cyc);
        check_outs("mid_new", 12'h400, 1'b1, 1'b0);

        // reset during step 4 (TH high)
        wait_falls(2);
        for (int i = 0; i < 100 && th !== 1'b1; i++) @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("k4_reset_th", {31'd0, th}, 32'd1);
        check_outs("k4_reset", 12'h000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        measure_first_fall("k4_first_fall_ce");

        // reset during step 5 (TH low)
        wait_falls(2);
        @(negedge clk);
        #2;
        check("k5_th_low", {31'd0, th}, 32'd0);
        rst = 1'b1;
        #1;
        check("k5_reset_th", {31'd0, th}, 32'd1);
        check_outs("k5_reset", 12'h000, 1'b0, 1'b0);
        pad_mode = 2;
        pad_btn  = 12'h091;
        @(negedge clk);
        rst = 1'b0;
        measure_first_fall("k5_first_fall_ce");
        wait_valid(cyc);
        check_outs("after_reset", 12'h091, 1'b1, 1'b1);

        // CE active one cycle in three
        ce_mode = 1'b1;
        wait_valid(cyc);
        f0 = falls; r0 = rises;
        wait_valid(cyc);
        check("ce3_period", cyc, 32'd768);
        check("ce3_th_falls", falls - f0, 32'd4);
        check("ce3_th_rises", rises - r0, 32'd4);
        check_outs("ce3", 12'h091, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
